// File: rtl/us_tx_engine.sv
// ---------------------------------------------------------------------------
// us_tx_engine
// Pops one 128-bit command at a time from the upstream command FIFO and emits
// a single TLP on the 64-bit TRN TX interface: Cpl, CplD (one DW read from
// the register file) or MWr32 carrying an incrementing DW test pattern.
// Completion of each TLP is reported back with a one-cycle pulse.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   us_cmd_fifo_*            FIFO read side (dout valid 1 cycle after rd_en)
//   rd_addr_o, rd_be_o       register-file address/byte enables from command
//   rd_data_i                register-file data (combinational from address)
//   cfg_completer_id_i       bus/dev/fn used as completer/requester ID
//   trn_t*                   TRN TX interface (active-low framing/handshake)
//   trn_tbuf_av_i            [1] posted credit, [2] completion credit
//   compl_done_o             pulse when a Cpl/CplD has been fully accepted
//   cmd_compl_o, cmd_id_o    pulse + channel ID when an MWr is fully accepted
//   bad_cmd_o                pulse when an invalid (type 3) command is dropped
// ---------------------------------------------------------------------------
module us_tx_engine #(
  parameter int MAX_PAYLOAD_BYTES = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] us_cmd_fifo_dout_i,
  input  logic         us_cmd_fifo_empty_i,
  output logic         us_cmd_fifo_rd_en_o,
  output logic [10:0]  rd_addr_o,
  output logic [3:0]   rd_be_o,
  input  logic [31:0]  rd_data_i,
  input  logic [15:0]  cfg_completer_id_i,
  output logic [63:0]  trn_td_o,
  output logic         trn_trem_n_o,
  output logic         trn_tsof_n_o,
  output logic         trn_teof_n_o,
  output logic         trn_tsrc_rdy_n_o,
  input  logic         trn_tdst_rdy_n_i,
  input  logic [3:0]   trn_tbuf_av_i,
  output logic         compl_done_o,
  output logic         cmd_compl_o,
  output logic [1:0]   cmd_id_o,
  output logic         bad_cmd_o
);

  localparam logic [10:0] MAX_DW_C = 11'(MAX_PAYLOAD_BYTES / 4);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_WAIT_BUF = 3'd2,
    ST_HDR0     = 3'd3,
    ST_HDR1     = 3'd4,
    ST_DATA     = 3'd5
  } state_t;

  state_t      state_r;
  logic        load_phase_r;   // 0: rd_en cycle, 1: FIFO data is valid
  logic [95:0] cmd_q_r;        // bits above 95 are never used
  logic [31:0] data_q_r;
  logic [7:0]  tag_cnt_r;
  logic [10:0] next_dw_r;      // index of the next payload DW to place on the bus

  logic        rd_en_r;
  logic [63:0] td_r;
  logic        trem_n_r;
  logic        tsof_n_r;
  logic        teof_n_r;
  logic        src_rdy_n_r;
  logic        compl_done_r;
  logic        cmd_compl_r;
  logic [1:0]  cmd_id_r;
  logic        bad_cmd_r;

  logic [1:0]  type_s;
  logic        is_mwr_s;
  logic [10:0] n_dw_s;
  logic        credit_ok_s;
  logic [31:0] hdr_dw0_s;
  logic [31:0] hdr_dw1_s;
  logic [31:0] hdr_dw2_s;
  logic [10:0] rem_dw_s;
  logic        data_last_s;
  logic        data_trem_s;
  logic [63:0] data_beat_s;
  logic        unused_s;

  // Payload size in DW: 2^len bytes, at least one DW, clamped to the max payload.
  function automatic logic [10:0] payload_dw(input logic [4:0] len);
    logic [10:0] n;
    if (len < 5'd2) begin
      n = 11'd1;
    end else if (len >= 5'd12) begin
      n = MAX_DW_C;
    end else begin
      n = 11'd1 << (len - 5'd2);
      if (n > MAX_DW_C) begin
        n = MAX_DW_C;
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  // Decode of the held command and assembly of header/payload words.
  always_comb begin
    type_s      = cmd_q_r[63:62];
    is_mwr_s    = (type_s == 2'd2);
    n_dw_s      = payload_dw(cmd_q_r[61:57]);
    credit_ok_s = is_mwr_s ? trn_tbuf_av_i[1] : trn_tbuf_av_i[2];
    if (is_mwr_s) begin
      hdr_dw0_s = {1'b0, 2'b10, 5'b00000, 1'b0, 3'b000, 4'b0000, 2'b00, 2'b00,
                   2'b00, n_dw_s[9:0]};
      hdr_dw1_s = {cfg_completer_id_i, tag_cnt_r,
                   (n_dw_s == 11'd1) ? 4'h0 : 4'hF, 4'hF};
      hdr_dw2_s = {cmd_q_r[95:66], 2'b00};
    end else begin
      hdr_dw0_s = {1'b0, (type_s == 2'd1) ? 2'b10 : 2'b00, 5'b01010, 1'b0,
                   cmd_q_r[54:52], 4'b0000, 2'b00, cmd_q_r[51:50], 2'b00, 10'd1};
      hdr_dw1_s = {cfg_completer_id_i, 3'b000, 1'b0, 12'd4};
      hdr_dw2_s = {cmd_q_r[39:24], cmd_q_r[23:16], 1'b0, cmd_q_r[6:0]};
    end
    // Payload DW k carries the value k; a beat holds DWs next and next+1.
    rem_dw_s    = n_dw_s - next_dw_r;
    data_last_s = (rem_dw_s <= 11'd2);
    data_trem_s = (rem_dw_s == 11'd1);
    data_beat_s = {{21'd0, next_dw_r},
                   data_trem_s ? 32'd0 : {21'd0, next_dw_r + 11'd1}};
  end

  // Fields of the FIFO word and credit vector that this engine never looks at.
  assign unused_s = ^{us_cmd_fifo_dout_i[127:96], trn_tbuf_av_i[3], trn_tbuf_av_i[0],
                      cmd_q_r[65:64], cmd_q_r[49:40], cmd_q_r[15:12], n_dw_s[10]};

  // Command FSM: fetch, credit wait, header/payload beats and completion pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      load_phase_r <= 1'b0;
      cmd_q_r      <= 96'd0;
      data_q_r     <= 32'd0;
      tag_cnt_r    <= 8'd0;
      next_dw_r    <= 11'd0;
      rd_en_r      <= 1'b0;
      td_r         <= 64'd0;
      trem_n_r     <= 1'b0;
      tsof_n_r     <= 1'b1;
      teof_n_r     <= 1'b1;
      src_rdy_n_r  <= 1'b1;
      compl_done_r <= 1'b0;
      cmd_compl_r  <= 1'b0;
      cmd_id_r     <= 2'd0;
      bad_cmd_r    <= 1'b0;
    end else begin
      rd_en_r      <= 1'b0;
      compl_done_r <= 1'b0;
      cmd_compl_r  <= 1'b0;
      bad_cmd_r    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (!us_cmd_fifo_empty_i) begin
            rd_en_r      <= 1'b1;
            load_phase_r <= 1'b0;
            state_r      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // The FIFO word appears the cycle after rd_en, so capture one cycle later.
          if (!load_phase_r) begin
            load_phase_r <= 1'b1;
          end else begin
            cmd_q_r <= us_cmd_fifo_dout_i[95:0];
            if (us_cmd_fifo_dout_i[63:62] == 2'd3) begin
              bad_cmd_r <= 1'b1;
              state_r   <= ST_IDLE;
            end else begin
              state_r <= ST_WAIT_BUF;
            end
          end
        end
        ST_WAIT_BUF: begin
          if (credit_ok_s) begin
            data_q_r    <= rd_data_i;
            td_r        <= {hdr_dw0_s, hdr_dw1_s};
            trem_n_r    <= 1'b0;
            tsof_n_r    <= 1'b0;
            teof_n_r    <= 1'b1;
            src_rdy_n_r <= 1'b0;
            state_r     <= ST_HDR0;
          end
        end
        ST_HDR0: begin
          if (!trn_tdst_rdy_n_i) begin
            tsof_n_r  <= 1'b1;
            next_dw_r <= 11'd1;
            state_r   <= ST_HDR1;
            case (type_s)
              2'd1: begin
                td_r     <= {hdr_dw2_s, data_q_r};
                trem_n_r <= 1'b0;
                teof_n_r <= 1'b0;
              end
              2'd2: begin
                td_r     <= {hdr_dw2_s, 32'd0};
                trem_n_r <= 1'b0;
                teof_n_r <= (n_dw_s == 11'd1) ? 1'b0 : 1'b1;
              end
              default: begin
                td_r     <= {hdr_dw2_s, 32'd0};
                trem_n_r <= 1'b1;
                teof_n_r <= 1'b0;
              end
            endcase
          end
        end
        ST_HDR1: begin
          if (!trn_tdst_rdy_n_i) begin
            if (!teof_n_r) begin
              src_rdy_n_r <= 1'b1;
              teof_n_r    <= 1'b1;
              trem_n_r    <= 1'b0;
              state_r     <= ST_IDLE;
              if (is_mwr_s) begin
                cmd_compl_r <= 1'b1;
                cmd_id_r    <= cmd_q_r[56:55];
                tag_cnt_r   <= tag_cnt_r + 8'd1;
              end else begin
                compl_done_r <= 1'b1;
              end
            end else begin
              td_r      <= data_beat_s;
              trem_n_r  <= data_trem_s;
              teof_n_r  <= !data_last_s;
              next_dw_r <= next_dw_r + 11'd2;
              state_r   <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (!trn_tdst_rdy_n_i) begin
            if (!teof_n_r) begin
              src_rdy_n_r <= 1'b1;
              teof_n_r    <= 1'b1;
              trem_n_r    <= 1'b0;
              cmd_compl_r <= 1'b1;
              cmd_id_r    <= cmd_q_r[56:55];
              tag_cnt_r   <= tag_cnt_r + 8'd1;
              state_r     <= ST_IDLE;
            end else begin
              td_r      <= data_beat_s;
              trem_n_r  <= data_trem_s;
              teof_n_r  <= !data_last_s;
              next_dw_r <= next_dw_r + 11'd2;
            end
          end
        end
        default: begin
          src_rdy_n_r <= 1'b1;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign us_cmd_fifo_rd_en_o = rd_en_r;
  assign rd_addr_o           = {3'b000, cmd_q_r[7:0]};
  assign rd_be_o             = cmd_q_r[11:8];
  assign trn_td_o            = td_r;
  assign trn_trem_n_o        = trem_n_r;
  assign trn_tsof_n_o        = tsof_n_r;
  assign trn_teof_n_o        = teof_n_r;
  assign trn_tsrc_rdy_n_o    = src_rdy_n_r;
  assign compl_done_o        = compl_done_r;
  assign cmd_compl_o         = cmd_compl_r;
  assign cmd_id_o            = cmd_id_r;
  assign bad_cmd_o           = bad_cmd_r;

endmodule

// File: tb/tb_us_tx_engine.sv
// ---------------------------------------------------------------------------
// tb_us_tx_engine
// Scoreboard bench for us_tx_engine. Each issued command is expanded by a
// TLP-level model (list of DWs packed two per beat) into expected beats and an
// expected completion event; a negedge monitor compares whatever the DUT
// presents against the heads of those queues.
// ---------------------------------------------------------------------------
module tb_us_tx_engine;
  localparam int MAXB = 128;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] dout;
  logic         empty;
  logic         rd_en;
  logic [10:0]  rd_addr;
  logic [3:0]   rd_be;
  logic [31:0]  rd_data;
  logic [15:0]  cid;
  logic [63:0]  td;
  logic         trem_n, tsof_n, teof_n, src_rdy_n, dst_rdy_n;
  logic [3:0]   tbuf;
  logic         compl_done, cmd_compl, bad_cmd;
  logic [1:0]   cmd_id;

  int compared = 0;
  int mismatched = 0;
  int beats_seen = 0;
  bit monitor_en = 1'b0;
  bit rand_bp = 1'b0;
  logic [7:0] tag_model;

  logic [31:0]  regfile [0:2047];
  logic [127:0] fifo_q [$];

  typedef struct {
    logic [63:0] td;
    logic        trem;
    logic        sof;
    logic        eof;
    bit          chk_lo;
    bit          chk_rd;
    logic [10:0] addr;
    logic [3:0]  be;
  } beat_t;
  typedef struct {
    int         kind;   // 0 Cpl/CplD done, 1 MWr done, 2 bad command
    logic [1:0] id;
  } ev_t;
  beat_t exp_beats [$];
  ev_t   exp_evs [$];

  us_tx_engine #(.MAX_PAYLOAD_BYTES(MAXB)) dut (
    .clk(clk), .rst(rst),
    .us_cmd_fifo_dout_i(dout), .us_cmd_fifo_empty_i(empty), .us_cmd_fifo_rd_en_o(rd_en),
    .rd_addr_o(rd_addr), .rd_be_o(rd_be), .rd_data_i(rd_data),
    .cfg_completer_id_i(cid),
    .trn_td_o(td), .trn_trem_n_o(trem_n), .trn_tsof_n_o(tsof_n), .trn_teof_n_o(teof_n),
    .trn_tsrc_rdy_n_o(src_rdy_n), .trn_tdst_rdy_n_i(dst_rdy_n), .trn_tbuf_av_i(tbuf),
    .compl_done_o(compl_done), .cmd_compl_o(cmd_compl), .cmd_id_o(cmd_id), .bad_cmd_o(bad_cmd)
  );

  always #5 clk = ~clk;

  assign rd_data = regfile[rd_addr];

  // FIFO model: pop on rd_en, word visible the cycle after.
  always @(posedge clk) begin
    if (rd_en && fifo_q.size() != 0) dout <= fifo_q.pop_front();
  end
  always @(negedge clk) empty = (fifo_q.size() == 0);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int payload_n(input logic [4:0] len);
    longint bytes;
    int n;
    bytes = longint'(1) << len;
    n = int'(bytes / 4);
    if (n < 1) n = 1;
    if (n > MAXB / 4) n = MAXB / 4;
    return n;
  endfunction

  function automatic logic [127:0] make_cmd(input logic [1:0] t, input logic [4:0] len,
      input logic [1:0] id, input logic [2:0] tc, input logic [1:0] attr, input logic [15:0] rid,
      input logic [7:0] tag, input logic [7:0] be, input logic [7:0] la, input logic [31:0] addr);
    return {$urandom(), addr, t, len, id, tc, attr, 10'($urandom()), rid, tag, be, la};
  endfunction

  // Expand a command into its TLP DW list, pack into beats, queue expectations.
  task automatic issue(input logic [127:0] cmd);
    logic [31:0] dws [$];
    logic [1:0]  t;
    int          n;
    beat_t       b;
    ev_t         e;
    t = cmd[63:62];
    e.id = 2'd0;
    if (t == 2'd3) begin
      e.kind = 2;
    end else if (t == 2'd2) begin
      n = payload_n(cmd[61:57]);
      dws.push_back({1'b0, 2'b10, 5'b00000, 1'b0, 3'b000, 4'b0000, 6'b000000, 10'(n)});
      dws.push_back({cid, tag_model, (n == 1) ? 4'h0 : 4'hF, 4'hF});
      dws.push_back({cmd[95:66], 2'b00});
      for (int k = 0; k < n; k++) dws.push_back(32'(k));
      tag_model = tag_model + 8'd1;
      e.kind = 1;
      e.id = cmd[56:55];
    end else begin
      dws.push_back({1'b0, (t == 2'd1) ? 2'b10 : 2'b00, 5'b01010, 1'b0, cmd[54:52], 4'b0000,
                     2'b00, cmd[51:50], 2'b00, 10'd1});
      dws.push_back({cid, 4'b0000, 12'd4});
      dws.push_back({cmd[39:24], cmd[23:16], 1'b0, cmd[6:0]});
      if (t == 2'd1) dws.push_back(regfile[{3'b000, cmd[7:0]}]);
      e.kind = 0;
    end
    if (t != 2'd3) begin
      for (int i = 0; i < dws.size(); i += 2) begin
        b.sof    = (i == 0);
        b.eof    = (i + 2 >= dws.size());
        b.trem   = (i + 1 >= dws.size());
        b.td     = {dws[i], b.trem ? 32'd0 : dws[i+1]};
        b.chk_lo = !b.trem || (t != 2'd2);
        b.chk_rd = (t != 2'd2) && (i == 2);
        b.addr   = {3'b000, cmd[7:0]};
        b.be     = cmd[11:8];
        exp_beats.push_back(b);
      end
    end
    exp_evs.push_back(e);
    fifo_q.push_back(cmd);
  endtask

  task automatic ev_check(input int kind, input logic [1:0] id);
    ev_t e;
    check("event_pending", 64'(exp_evs.size() != 0), 64'd1);
    if (exp_evs.size() != 0) begin
      e = exp_evs.pop_front();
      check("event_kind", 64'(kind), 64'(e.kind));
      if (kind == 1) check("cmd_id", 64'(id), 64'(e.id));
    end
  endtask

  // Monitor: compare presented beats (held or accepted) and completion pulses.
  always @(negedge clk) begin
    beat_t b;
    if (!rst && monitor_en) begin
      if (src_rdy_n === 1'b0) begin
        check("beat_pending", 64'(exp_beats.size() != 0), 64'd1);
        if (exp_beats.size() != 0) begin
          b = exp_beats[0];
          check("td_hi", 64'(td[63:32]), 64'(b.td[63:32]));
          if (b.chk_lo) check("td_lo", 64'(td[31:0]), 64'(b.td[31:0]));
          check("trem_n", 64'(trem_n), 64'(b.trem));
          check("tsof_n", 64'(tsof_n), 64'(!b.sof));
          check("teof_n", 64'(teof_n), 64'(!b.eof));
          if (dst_rdy_n === 1'b0) begin
            if (b.chk_rd) begin
              check("rd_addr", 64'(rd_addr), 64'(b.addr));
              check("rd_be", 64'(rd_be), 64'(b.be));
            end
            void'(exp_beats.pop_front());
            beats_seen++;
          end
        end
      end
      if (compl_done === 1'b1) ev_check(0, 2'd0);
      if (cmd_compl === 1'b1)  ev_check(1, cmd_id);
      if (bad_cmd === 1'b1)    ev_check(2, 2'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_bp) begin
      dst_rdy_n = ($urandom_range(0, 99) < 40);
      tbuf = {1'b0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), 1'b0};
    end
  endtask

  task automatic drain(input int limit);
    int cyc = 0;
    while ((exp_beats.size() != 0 || exp_evs.size() != 0 || fifo_q.size() != 0) && cyc < limit) begin
      tick();
      cyc++;
    end
    check("drain_in_time", 64'(cyc < limit), 64'd1);
    repeat (4) tick();
  endtask

  task automatic wait_no_credit(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check(name, 64'(src_rdy_n), 64'd1);
      tick();
    end
  endtask

  initial begin
    logic [1:0] t;
    int start;
    int cyc;
    for (int i = 0; i < 2048; i++) regfile[i] = $urandom();
    regfile[8] = 32'h12345678;
    cid = 16'h0200;
    rst = 1'b1;
    dst_rdy_n = 1'b1;
    tbuf = 4'b0110;
    dout = 128'd0;
    empty = 1'b1;
    tag_model = 8'd0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_rd_en", 64'(rd_en), 64'd0);
    check("rst_td", td, 64'd0);
    check("rst_trem_n", 64'(trem_n), 64'd0);
    check("rst_tsof_n", 64'(tsof_n), 64'd1);
    check("rst_teof_n", 64'(teof_n), 64'd1);
    check("rst_src_rdy_n", 64'(src_rdy_n), 64'd1);
    check("rst_compl_done", 64'(compl_done), 64'd0);
    check("rst_cmd_compl", 64'(cmd_compl), 64'd0);
    check("rst_cmd_id", 64'(cmd_id), 64'd0);
    check("rst_bad_cmd", 64'(bad_cmd), 64'd0);
    check("rst_rd_addr", 64'(rd_addr), 64'd0);
    rst = 1'b0;
    monitor_en = 1'b1;
    tick();
    dst_rdy_n = 1'b0;

    // Directed: CplD, Cpl, MWr N=16, clamps, single-DW MWr.
    issue(make_cmd(2'd1, 5'd2, 2'd0, 3'd0, 2'd0, 16'h0100, 8'h2A, 8'h0F, 8'h08, 32'd0));
    drain(200);
    issue(make_cmd(2'd0, 5'd2, 2'd0, 3'd0, 2'd0, 16'h0100, 8'h11, 8'h0F, 8'h08, 32'd0));
    drain(200);
    issue(make_cmd(2'd2, 5'd6, 2'd1, 3'd0, 2'd0, 16'h0000, 8'h00, 8'h00, 8'h00, 32'h10000000));
    drain(200);
    issue(make_cmd(2'd2, 5'd10, 2'd2, 3'd0, 2'd0, 16'h0000, 8'h00, 8'h00, 8'h00, 32'h2000_0004));
    issue(make_cmd(2'd2, 5'd0, 2'd3, 3'd0, 2'd0, 16'h0000, 8'h00, 8'h00, 8'h00, 32'h3000_0008));
    issue(make_cmd(2'd2, 5'd13, 2'd0, 3'd0, 2'd0, 16'h0000, 8'h00, 8'h00, 8'h00, 32'h4000_0010));
    drain(500);

    // Credits: MWr waits without posted credit, Cpl waits without completion credit.
    tbuf = 4'b0100;
    issue(make_cmd(2'd2, 5'd4, 2'd1, 3'd0, 2'd0, 16'h0000, 8'h00, 8'h00, 8'h00, 32'h5000_0000));
    wait_no_credit("src_rdy_n_no_posted_credit", 20);
    tbuf = 4'b0110;
    drain(200);
    tbuf = 4'b0010;
    issue(make_cmd(2'd1, 5'd2, 2'd0, 3'd5, 2'd2, 16'hBEEF, 8'h33, 8'hA5, 8'h40, 32'd0));
    wait_no_credit("src_rdy_n_no_cpl_credit", 20);
    tbuf = 4'b0110;
    drain(200);

    // Invalid command: only a bad_cmd pulse.
    issue(make_cmd(2'd3, 5'd5, 2'd2, 3'd0, 2'd0, 16'h0000, 8'h00, 8'h00, 8'h00, 32'h0));
    drain(200);

    // Randomized traffic with backpressure and credit toggling.
    rand_bp = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cyc = $urandom_range(0, 9);
      t = (cyc < 3) ? 2'd0 : (cyc < 6) ? 2'd1 : (cyc < 9) ? 2'd2 : 2'd3;
      issue(make_cmd(t, 5'($urandom_range(0, 15)), 2'($urandom()), 3'($urandom()),
                     2'($urandom()), 16'($urandom()), 8'($urandom()), 8'($urandom()),
                     8'($urandom()), $urandom()));
      repeat ($urandom_range(0, 6)) tick();
    end
    drain(20000);
    rand_bp = 1'b0;
    dst_rdy_n = 1'b0;
    tbuf = 4'b0110;

    // Reset in the middle of a long MWr.
    issue(make_cmd(2'd2, 5'd8, 2'd2, 3'd0, 2'd0, 16'h0000, 8'h00, 8'h00, 8'h00, 32'h6000_0000));
    start = beats_seen;
    cyc = 0;
    while (beats_seen < start + 3 && cyc < 200) begin
      tick();
      cyc++;
    end
    check("mid_packet_reached", 64'(beats_seen >= start + 3), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_beats.delete();
    exp_evs.delete();
    fifo_q.delete();
    tag_model = 8'd0;
    @(negedge clk);
    check("mid_rst_src_rdy_n", 64'(src_rdy_n), 64'd1);
    check("mid_rst_cmd_compl", 64'(cmd_compl), 64'd0);
    check("mid_rst_teof_n", 64'(teof_n), 64'd1);
    rst = 1'b0;
    repeat (3) tick();
    issue(make_cmd(2'd2, 5'd0, 2'd1, 3'd0, 2'd0, 16'h0000, 8'h00, 8'h00, 8'h00, 32'h7000_0000));
    issue(make_cmd(2'd2, 5'd3, 2'd0, 3'd0, 2'd0, 16'h0000, 8'h00, 8'h00, 8'h00, 32'h7000_1000));
    drain(300);

    check("beats_left", 64'(exp_beats.size()), 64'd0);
    check("events_left", 64'(exp_evs.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
